// File: rtl/cv32e40p_tb_mem_arbiter.sv
// cv32e40p_tb_mem_arbiter: shares a 1-cycle single-port tb RAM between instr and data OBI ports.
// Define CV32E40P_TB_ARB_RR_EN for round-robin ties; default is data-first fixed priority.
module cv32e40p_tb_mem_arbiter #(
    parameter int ADDR_WIDTH   = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_INSTR, OWN_DATA} owner_e;

    owner_e                owner_q, owner_d;
    logic                  we_q;
    logic [CW-1:0]         instr_wait_q, data_wait_q;
    logic [DATA_WIDTH-1:0] instr_rdata_q, data_rdata_q;
    logic                  policy_data, pick_data;

`ifdef CV32E40P_TB_ARB_RR_EN
    logic last_data_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) last_data_q <= 1'b0;
        else if (instr_gnt_o || data_gnt_o) last_data_q <= data_gnt_o;
    end
    assign policy_data = !last_data_q;
`else
    assign policy_data = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q       <= OWN_NONE;
            we_q          <= 1'b0;
            instr_wait_q  <= '0;
            data_wait_q   <= '0;
            instr_rdata_q <= '0;
            data_rdata_q  <= '0;
        end else begin
            owner_q       <= owner_d;
            we_q          <= data_gnt_o & data_we_i;
            instr_wait_q  <= (instr_req_i && !instr_gnt_o) ?
                             ((instr_wait_q == LIMIT) ? LIMIT : instr_wait_q + CW'(1)) : '0;
            data_wait_q   <= (data_req_i && !data_gnt_o) ?
                             ((data_wait_q == LIMIT) ? LIMIT : data_wait_q + CW'(1)) : '0;
            instr_rdata_q <= instr_rdata_o;
            data_rdata_q  <= data_rdata_o;
        end
    end

    // A starved port overrides the tie-break policy
    always_comb begin
        pick_data   = (data_wait_q == LIMIT) ? 1'b1 : (instr_wait_q == LIMIT) ? 1'b0 : policy_data;
        data_gnt_o  = !rst_i && data_req_i && (!instr_req_i || pick_data);
        instr_gnt_o = !rst_i && instr_req_i && !data_gnt_o;
        owner_d     = data_gnt_o ? OWN_DATA : instr_gnt_o ? OWN_INSTR : OWN_NONE;
    end

    always_comb begin
        instr_rvalid_o = !rst_i && (owner_q == OWN_INSTR);
        data_rvalid_o  = !rst_i && (owner_q == OWN_DATA);
        instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : instr_rdata_q;
        data_rdata_o   = data_rvalid_o ? (we_q ? '0 : mem_rdata_i) : data_rdata_q;
        mem_req_o      = instr_gnt_o | data_gnt_o;
        mem_addr_o     = data_gnt_o ? data_addr_i : {instr_addr_i[ADDR_WIDTH-1:2], 2'b00};
        mem_we_o       = data_gnt_o & data_we_i;
        mem_be_o       = data_gnt_o ? data_be_i : 4'hF;
        mem_wdata_o    = data_wdata_i;
    end
endmodule

// File: tb/tb_cv32e40p_tb_mem_arbiter.sv
// tb_cv32e40p_tb_mem_arbiter: directed table, arbitration/reset sequences and a random scoreboard run.
module tb_cv32e40p_tb_mem_arbiter;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        instr_req_i = 1'b0, instr_gnt_o, instr_rvalid_o;
    logic [19:0] instr_addr_i = '0;
    logic [31:0] instr_rdata_o;
    logic        data_req_i = 1'b0, data_we_i = 1'b0, data_gnt_o, data_rvalid_o;
    logic [19:0] data_addr_i = '0;
    logic [3:0]  data_be_i = '0;
    logic [31:0] data_wdata_i = '0, data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [19:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o, mem_rdata_i = '0;

    int passed = 0, total = 0;

    cv32e40p_tb_mem_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural single-port RAM, 1-cycle read latency
    logic [31:0] ram [0:(1<<18)-1];
    always @(posedge clk_i) begin
        if (mem_req_o) begin
            mem_rdata_i <= ram[mem_addr_o[19:2]];
            if (mem_we_o)
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram[mem_addr_o[19:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
    end

    function automatic logic [31:0] init_word(input logic [17:0] w);
        return 32'hA500_0000 | {14'd0, w};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    task automatic idle_inputs();
        instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic        ireq;
        logic [19:0] iaddr;
        logic        dreq;
        logic [19:0] daddr;
        logic        dwe;
        logic [3:0]  dbe;
        logic [31:0] wd;
        logic        eig, edg, eirv, edrv;
        logic [31:0] eir, edr;
    } vec_t;

    vec_t v [12];
    logic [31:0] ref_mem [int];
    logic        pi, pd;
    logic [31:0] pi_data, pd_data;

    initial begin
        for (int i = 0; i < (1 << 18); i++) ram[i] = init_word(18'(i));
        v[0]  = '{0, 20'h0,   0, 20'h0,    0, 4'h0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0};
        v[1]  = '{1, 20'h180, 0, 20'h0,    0, 4'h0, 32'h0,        1, 0, 0, 0, 32'h0,        32'h0};
        v[2]  = '{1, 20'h184, 0, 20'h0,    0, 4'h0, 32'h0,        1, 0, 1, 0, 32'hA5000060, 32'h0};
        v[3]  = '{1, 20'h188, 0, 20'h0,    0, 4'h0, 32'h0,        1, 0, 1, 0, 32'hA5000061, 32'h0};
        v[4]  = '{0, 20'h0,   1, 20'h1000, 1, 4'hF, 32'hDEADBEEF, 0, 1, 1, 0, 32'hA5000062, 32'h0};
        v[5]  = '{0, 20'h0,   1, 20'h1000, 0, 4'hF, 32'h0,        0, 1, 0, 1, 32'hA5000062, 32'h0};
        v[6]  = '{0, 20'h0,   1, 20'h2000, 1, 4'hF, 32'h11223344, 0, 1, 0, 1, 32'hA5000062, 32'hDEADBEEF};
        v[7]  = '{0, 20'h0,   1, 20'h2000, 1, 4'h2, 32'h0000AB00, 0, 1, 0, 1, 32'hA5000062, 32'h0};
        v[8]  = '{0, 20'h0,   1, 20'h2000, 0, 4'hF, 32'h0,        0, 1, 0, 1, 32'hA5000062, 32'h0};
        v[9]  = '{1, 20'h18F, 0, 20'h0,    0, 4'h0, 32'h0,        1, 0, 0, 1, 32'hA5000062, 32'h1122AB44};
        v[10] = '{0, 20'h0,   0, 20'h0,    0, 4'h0, 32'h0,        0, 0, 1, 0, 32'hA5000063, 32'h1122AB44};
        v[11] = '{0, 20'h0,   0, 20'h0,    0, 4'h0, 32'h0,        0, 0, 0, 0, 32'hA5000063, 32'h1122AB44};

        do_reset();
        for (int k = 0; k < 12; k++) begin
            instr_req_i = v[k].ireq; instr_addr_i = v[k].iaddr;
            data_req_i = v[k].dreq; data_addr_i = v[k].daddr; data_we_i = v[k].dwe;
            data_be_i = v[k].dbe; data_wdata_i = v[k].wd;
            #1;
            chk($sformatf("v%0d_ignt", k), 32'(instr_gnt_o), 32'(v[k].eig));
            chk($sformatf("v%0d_dgnt", k), 32'(data_gnt_o), 32'(v[k].edg));
            chk($sformatf("v%0d_mreq", k), 32'(mem_req_o), 32'(v[k].eig | v[k].edg));
            chk($sformatf("v%0d_irv", k), 32'(instr_rvalid_o), 32'(v[k].eirv));
            chk($sformatf("v%0d_drv", k), 32'(data_rvalid_o), 32'(v[k].edrv));
            chk($sformatf("v%0d_irdata", k), instr_rdata_o, v[k].eir);
            chk($sformatf("v%0d_drdata", k), data_rdata_o, v[k].edr);
            @(negedge clk_i);
        end

        // Both ports requesting continuously from reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            instr_req_i = 1'b1; instr_addr_i = 20'h200;
            data_req_i = 1'b1; data_addr_i = 20'h3000; data_we_i = 1'b0;
            #1;
`ifdef CV32E40P_TB_ARB_RR_EN
            chk($sformatf("tie%0d_dgnt", i), 32'(data_gnt_o), 32'(i % 2 == 0));
`else
            chk($sformatf("tie%0d_dgnt", i), 32'(data_gnt_o), 32'(i % 5 != 4));
`endif
            chk($sformatf("tie%0d_onehot", i), 32'(instr_gnt_o ^ data_gnt_o), 32'd1);
            @(negedge clk_i);
        end
        idle_inputs();

        // Reset in the response cycle of an instr read
        do_reset();
        instr_req_i = 1'b1; instr_addr_i = 20'h180;
        #1 chk("rst_mid_igrant", 32'(instr_gnt_o), 32'd1);
        @(negedge clk_i);
        instr_req_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("rst_mid_irv%0d", i), 32'(instr_rvalid_o), 32'd0);
            chk($sformatf("rst_mid_drv%0d", i), 32'(data_rvalid_o), 32'd0);
            chk($sformatf("rst_mid_irdata%0d", i), instr_rdata_o, 32'd0);
            @(negedge clk_i);
        end
        instr_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b0;
        #1;
        chk("rst_first_dgnt", 32'(data_gnt_o), 32'd1);
        chk("rst_first_igntl", 32'(instr_gnt_o), 32'd0);
        @(negedge clk_i);
        idle_inputs();

        // Random traffic against a reference memory built from the stimulus
        do_reset();
        pi = 1'b0; pd = 1'b0; pi_data = '0; pd_data = '0;
        for (int c = 0; c < 2000; c++) begin
            logic [17:0] wi, wd;
            logic [31:0] t;
            instr_req_i  = 1'($urandom_range(0, 1));
            instr_addr_i = 20'h04000 + 20'($urandom_range(0, 15) << 2) + 20'($urandom_range(0, 3));
            data_req_i   = 1'($urandom_range(0, 1));
            data_addr_i  = 20'h04000 + 20'($urandom_range(0, 15) << 2);
            data_we_i    = 1'($urandom_range(0, 1));
            data_be_i    = 4'($urandom_range(0, 15));
            data_wdata_i = $urandom;
            #1;
            chk("rnd_irv", 32'(instr_rvalid_o), 32'(pi));
            chk("rnd_drv", 32'(data_rvalid_o), 32'(pd));
            if (pi) chk("rnd_irdata", instr_rdata_o, pi_data);
            if (pd) chk("rnd_drdata", data_rdata_o, pd_data);
            chk("rnd_two_gnt", 32'(instr_gnt_o & data_gnt_o), 32'd0);
            chk("rnd_any_gnt", 32'(instr_gnt_o | data_gnt_o), 32'(instr_req_i | data_req_i));
            wi = instr_addr_i[19:2];
            wd = data_addr_i[19:2];
            pi = instr_gnt_o & instr_req_i;
            pd = data_gnt_o & data_req_i;
            pi_data = ref_mem.exists(int'(wi)) ? ref_mem[int'(wi)] : init_word(wi);
            t = ref_mem.exists(int'(wd)) ? ref_mem[int'(wd)] : init_word(wd);
            pd_data = data_we_i ? 32'h0 : t;
            if (pd && data_we_i) begin
                for (int b = 0; b < 4; b++)
                    if (data_be_i[b]) t[8*b +: 8] = data_wdata_i[8*b +: 8];
                ref_mem[int'(wd)] = t;
            end
            @(negedge clk_i);
        end
        idle_inputs();
        #1;
        chk("rnd_last_irv", 32'(instr_rvalid_o), 32'(pi));
        chk("rnd_last_drv", 32'(data_rvalid_o), 32'(pd));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
